load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Load-side counterpart of the store byte-enable logic.
- Takes a load request (byte address, DataType, unsigned flag) from the execute stage and issues one or two word reads to data memory.
- Extracts the addressed byte, halfword or word, handling offsets that cross a word boundary.
- Sign- or zero-extends the result to 32 bits and returns it to writeback with a done pulse.

Parameters:
- ADDR_W, 32, byte-address width; MemAddr low 2 bits always 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- LoadStart  in  1  request strobe; sampled only in IDLE
- ALUResult  in  ADDR_W  byte address of load, captured on accepted LoadStart
- DataType  in  2  00 byte, 01 halfword, 10/11 word; captured with ALUResult
- Unsigned  in  1  1 = zero-extend, 0 = sign-extend; ignored for word; captured with ALUResult
- Busy  out  1  high from the cycle after an accepted start through the Done cycle
- Done  out  1  one-cycle pulse; LoadData valid this cycle
- LoadData  out  32  extended result; holds until next Done
- MemRead  out  1  word read request; held until MemReady
- MemAddr  out  ADDR_W  word-aligned read address
- MemRdata  in  32  read word, little-endian (byte0 = bits 7:0); valid when MemReady
- MemReady  in  1  read data valid; honoured only while MemRead = 1

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE; Busy, Done, MemRead = 0; MemAddr = 0; LoadData = 0; captured registers cleared.
  - Reset mid-operation abandons the access; no Done pulse is issued.
- States: IDLE, WAIT0, WAIT1, DONE.
- IDLE:
  - LoadStart = 1 → capture Addr, DataType, Unsigned.
  - Next state WAIT0 with MemRead = 1, MemAddr = {Addr[ADDR_W-1:2], 2'b00}.
- Split condition (evaluated on captured values):
  - Word: Addr[1:0] != 0.
  - Halfword: Addr[1:0] = 3.
  - Byte: never.
- WAIT0:
  - On MemReady, latch MemRdata into Lo.
  - If split: next WAIT1, MemAddr += 4 (wraps modulo 2^ADDR_W), MemRead stays 1.
  - Otherwise: next DONE, MemRead = 0.
- WAIT1:
  - On MemReady, latch MemRdata into Hi; next DONE, MemRead = 0.
- DONE:
  - Done = 1 for exactly one cycle; LoadData registered this cycle; next IDLE.
- Data assembly:
  - Form 64-bit {Hi, Lo}; Hi = 0 when no split.
  - Shift right by 8*Addr[1:0]; take low 8/16/32 bits per DataType.
  - Extend with bit 7 or 15 when Unsigned = 0; zero-fill when Unsigned = 1.
- Latency: start accepted cycle N; first MemRead cycle N+1.
  - MemReady may arrive any cycle ≥ N+1, including the same cycle MemRead rises.
  - Minimum Done: N+2 unsplit, N+3 split.
- LoadStart while Busy is ignored and not queued.
- LoadStart is accepted in the cycle after Done (back-to-back loads).
- MemReady when MemRead = 0 is ignored.
- MemAddr and MemRead are registered outputs; no combinational path from LoadStart to MemRead.

Test Plan:
Memory contents: word 0x100 = 0x80FF7F01, word 0x104 = 0x44332211; MemReady 0-cycle latency unless stated.
- LB 0x101 (signed) → Done N+2, LoadData 0x0000007F. LB 0x102 → 0xFFFFFFFF. LBU 0x102 → 0x000000FF. One MemRead each, MemAddr 0x100.
- LH 0x102 signed → 0xFFFF80FF. LHU 0x102 → 0x000080FF. Single read.
- LH 0x103 → reads 0x100 then 0x104, Done N+3, LoadData 0x00001180.
- LW 0x103 → two reads, 0x33221180. LW 0x100 → single read, 0x80FF7F01.
- MemReady delayed 3 cycles on each read of LW 0x101:
  - MemRead/MemAddr held stable throughout; result 0x1180FF7F; Done N+8.
  - LoadStart pulsed during Busy produces no extra access.
- rst_n low during WAIT1 of LW 0x102:
  - Next cycle MemRead = 0, Busy = 0, no Done, LoadData = 0.
  - A subsequent LB 0x100 returns 0x00000001.

Source files
------------

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two aligned word reads for a byte/half/word load,
// extracts the addressed bytes across a word boundary and sign/zero-extends the result.
module load_align_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LoadStart,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [1:0]        DataType,
  input  logic              Unsigned,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       LoadData,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [31:0]       MemRdata,
  input  logic              MemReady
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OFF_W  = 2;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT state;
  stateT stateNext;

  // Captured request attributes
  logic [OFF_W-1:0] addrOff;
  logic [1:0]       dataTypeQ;
  logic             unsignedQ;
  logic [DATA_W-1:0] loWord;

  // Next values for every register held in the datapath process
  logic [OFF_W-1:0]  addrOffNext;
  logic [1:0]        dataTypeNext;
  logic              unsignedNext;
  logic [DATA_W-1:0] loWordNext;
  logic              busyNext;
  logic              doneNext;
  logic              memReadNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] loadDataNext;

  logic readAck;
  logic isSplit;

  // A response only counts while a read is actually outstanding
  assign readAck = MemRead && MemReady;

  // Word loads split on any misalignment, halfwords only when they start in the last byte
  assign isSplit = (dataTypeQ[1] && (addrOff != OFF_W'(0))) ||
                   ((dataTypeQ == DT_HALF) && (addrOff == OFF_W'(3)));

  // Shift the {hi,lo} pair down to the addressed byte, then size and extend
  function automatic logic [DATA_W-1:0] alignData(
    input logic [DATA_W-1:0] hiWord,
    input logic [DATA_W-1:0] loW,
    input logic [OFF_W-1:0]  off,
    input logic [1:0]        dType,
    input logic              zeroExt
  );
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] res;
    shifted = DATA_W'({hiWord, loW} >> {off, 3'b000});
    case (dType)
      DT_BYTE: begin
        if (zeroExt) begin
          res = DATA_W'(shifted[BYTE_W-1:0]);
        end else begin
          res = {{(DATA_W-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
        end
      end
      DT_HALF: begin
        if (zeroExt) begin
          res = DATA_W'(shifted[HALF_W-1:0]);
        end else begin
          res = {{(DATA_W-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
        end
      end
      default: res = shifted;
    endcase
    return res;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (LoadStart) begin
          stateNext = WAIT0;
        end
      end
      WAIT0: begin
        if (readAck) begin
          stateNext = isSplit ? WAIT1 : DONE;
        end
      end
      WAIT1: begin
        if (readAck) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    addrOffNext  = addrOff;
    dataTypeNext = dataTypeQ;
    unsignedNext = unsignedQ;
    loWordNext   = loWord;
    busyNext     = Busy;
    doneNext     = 1'b0;
    memReadNext  = MemRead;
    memAddrNext  = MemAddr;
    loadDataNext = LoadData;
    case (state)
      IDLE: begin
        if (LoadStart) begin
          addrOffNext  = ALUResult[OFF_W-1:0];
          dataTypeNext = DataType;
          unsignedNext = Unsigned;
          busyNext     = 1'b1;
          memReadNext  = 1'b1;
          memAddrNext  = {ALUResult[ADDR_W-1:OFF_W], OFF_W'(0)};
        end
      end
      WAIT0: begin
        if (readAck) begin
          loWordNext = MemRdata;
          if (isSplit) begin
            memAddrNext = MemAddr + ADDR_W'(4);
          end else begin
            memReadNext  = 1'b0;
            doneNext     = 1'b1;
            loadDataNext = alignData(DATA_W'(0), MemRdata, addrOff, dataTypeQ, unsignedQ);
          end
        end
      end
      WAIT1: begin
        if (readAck) begin
          memReadNext  = 1'b0;
          doneNext     = 1'b1;
          loadDataNext = alignData(MemRdata, loWord, addrOff, dataTypeQ, unsignedQ);
        end
      end
      DONE: begin
        busyNext = 1'b0;
      end
      default: begin
        busyNext    = 1'b0;
        memReadNext = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addrOff   <= '0;
      dataTypeQ <= '0;
      unsignedQ <= 1'b0;
      loWord    <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      MemRead   <= 1'b0;
      MemAddr   <= '0;
      LoadData  <= '0;
    end else begin
      addrOff   <= addrOffNext;
      dataTypeQ <= dataTypeNext;
      unsignedQ <= unsignedNext;
      loWord    <= loWordNext;
      Busy      <= busyNext;
      Done      <= doneNext;
      MemRead   <= memReadNext;
      MemAddr   <= memAddrNext;
      LoadData  <= loadDataNext;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed loads push expected reads and results,
// a negedge monitor checks every read handshake and Done pulse against them.
module tb_load_align_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              LoadStart;
  logic [ADDR_W-1:0] ALUResult;
  logic [1:0]        DataType;
  logic              Unsigned;
  logic              Busy;
  logic              Done;
  logic [31:0]       LoadData;
  logic              MemRead;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemRdata;
  logic              MemReady;

  load_align_unit #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .LoadStart (LoadStart),
    .ALUResult (ALUResult),
    .DataType  (DataType),
    .Unsigned  (Unsigned),
    .Busy      (Busy),
    .Done      (Done),
    .LoadData  (LoadData),
    .MemRead   (MemRead),
    .MemAddr   (MemAddr),
    .MemRdata  (MemRdata),
    .MemReady  (MemReady)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: responses are spaced 'delay' cycles apart, the first counted from the request rising
  int delay = 0;
  int rdCnt = 0;
  assign MemReady = MemRead && (rdCnt >= delay);
  always @(posedge clk) begin
    if (!MemRead)      rdCnt <= 0;
    else if (MemReady) rdCnt <= 1;
    else               rdCnt <= rdCnt + 1;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h80FF_7F01;
      32'h0000_0104: return 32'h4433_2211;
      32'hFFFF_FFFC: return 32'hDDCC_BBAA;
      32'h0000_0000: return 32'h8765_4321;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction
  assign MemRdata = memWord(MemAddr);

  typedef struct {
    int          cycle;
    logic [31:0] data;
  } doneExpT;

  doneExpT     doneQ[$];
  logic [31:0] addrQ[$];
  int          nCmp = 0;
  int          nErr = 0;
  logic [31:0] lastData = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic        prevDone = 1'b0;
  logic        holdPend = 1'b0;
  logic [31:0] holdAddr = 32'h0;
  doneExpT     e;
  always @(negedge clk) begin
    if (holdPend) begin
      check("memread_held", 32'(MemRead), 32'd1);
      check("memaddr_held", MemAddr, holdAddr);
    end
    if (MemRead && MemReady) begin
      if (addrQ.size() == 0) begin
        nCmp++;
        nErr++;
        $display("FAIL unexpected_read: got addr 0x%08h, expected no read (cycle %0d)", MemAddr, cyc);
      end else begin
        check("read_addr", MemAddr, addrQ.pop_front());
      end
    end
    if (Done) begin
      if (doneQ.size() == 0) begin
        nCmp++;
        nErr++;
        $display("FAIL unexpected_done: got Done with data 0x%08h, expected none (cycle %0d)", LoadData, cyc);
      end else begin
        e = doneQ.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.cycle));
        check("load_data", LoadData, e.data);
        check("busy_at_done", 32'(Busy), 32'd1);
      end
      if (prevDone) begin
        nCmp++;
        nErr++;
        $display("FAIL done_pulse_width: got Done high 2 cycles, expected 1 (cycle %0d)", cyc);
      end
    end
    prevDone = Done;
    holdPend = MemRead && !MemReady && rst_n;
    holdAddr = MemAddr;
  end

  // Issue one load in the cycle after the previous call returned; returns in the expected Done cycle
  task automatic doLoad(input logic [31:0] addr, input logic [1:0] dt, input logic uns,
                        input logic [31:0] expData, input int lat, input int nReads,
                        input logic [31:0] a0, input logic [31:0] a1, input bit poke);
    int      n;
    doneExpT d;
    @(posedge clk); #1;
    LoadStart = 1'b1;
    ALUResult = addr;
    DataType  = dt;
    Unsigned  = uns;
    n = cyc;
    d.cycle = n + lat;
    d.data  = expData;
    doneQ.push_back(d);
    addrQ.push_back(a0);
    if (nReads == 2) addrQ.push_back(a1);
    @(posedge clk); #1;
    LoadStart = 1'b0;
    ALUResult = 32'h0000_0FF0;
    DataType  = 2'b11;
    Unsigned  = ~uns;
    check("busy_after_start", 32'(Busy), 32'd1);
    check("loaddata_hold", LoadData, lastData);
    for (int i = 2; i <= lat; i++) begin
      @(posedge clk); #1;
      if (poke && (i == 3 || i == 6)) begin
        LoadStart = 1'b1;
        ALUResult = 32'h0000_0200;
      end else begin
        LoadStart = 1'b0;
      end
    end
    lastData = expData;
  endtask

  initial begin
    rst_n     = 1'b0;
    LoadStart = 1'b0;
    ALUResult = '0;
    DataType  = 2'b00;
    Unsigned  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_memread", 32'(MemRead), 32'd0);
    check("reset_memaddr", MemAddr, 32'h0);
    check("reset_loaddata", LoadData, 32'h0);
    rst_n = 1'b1;

    doLoad(32'h101, 2'b00, 1'b0, 32'h0000_007F, 2, 1, 32'h100, 32'h0, 1'b0);
    doLoad(32'h102, 2'b00, 1'b0, 32'hFFFF_FFFF, 2, 1, 32'h100, 32'h0, 1'b0);
    doLoad(32'h102, 2'b00, 1'b1, 32'h0000_00FF, 2, 1, 32'h100, 32'h0, 1'b0);
    doLoad(32'h103, 2'b00, 1'b0, 32'hFFFF_FF80, 2, 1, 32'h100, 32'h0, 1'b0);
    doLoad(32'h102, 2'b01, 1'b0, 32'hFFFF_80FF, 2, 1, 32'h100, 32'h0, 1'b0);
    doLoad(32'h102, 2'b01, 1'b1, 32'h0000_80FF, 2, 1, 32'h100, 32'h0, 1'b0);
    doLoad(32'h101, 2'b01, 1'b0, 32'hFFFF_FF7F, 2, 1, 32'h100, 32'h0, 1'b0);
    doLoad(32'h103, 2'b01, 1'b0, 32'h0000_1180, 3, 2, 32'h100, 32'h104, 1'b0);
    doLoad(32'h103, 2'b10, 1'b0, 32'h3322_1180, 3, 2, 32'h100, 32'h104, 1'b0);
    doLoad(32'h100, 2'b10, 1'b0, 32'h80FF_7F01, 2, 1, 32'h100, 32'h0, 1'b0);
    doLoad(32'h102, 2'b11, 1'b1, 32'h2211_80FF, 3, 2, 32'h100, 32'h104, 1'b0);
    doLoad(32'hFFFF_FFFF, 2'b10, 1'b0, 32'h6543_21DD, 3, 2, 32'hFFFF_FFFC, 32'h0, 1'b0);

    delay = 3;
    doLoad(32'h101, 2'b10, 1'b0, 32'h1180_FF7F, 8, 2, 32'h100, 32'h104, 1'b1);
    delay = 0;

    // Reset while the second word of a split word load is outstanding
    @(posedge clk); #1;
    LoadStart = 1'b1;
    ALUResult = 32'h102;
    DataType  = 2'b10;
    Unsigned  = 1'b0;
    addrQ.push_back(32'h100);
    addrQ.push_back(32'h104);
    @(posedge clk); #1;
    LoadStart = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_memread", 32'(MemRead), 32'd0);
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check("rst_mid_done", 32'(Done), 32'd0);
    check("rst_mid_loaddata", LoadData, 32'h0);
    rst_n = 1'b1;
    lastData = 32'h0;

    doLoad(32'h100, 2'b00, 1'b0, 32'h0000_0001, 2, 1, 32'h100, 32'h0, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("done_queue_empty", 32'(doneQ.size()), 32'd0);
    check("read_queue_empty", 32'(addrQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
